// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   ST_IDLE / ST_SHIFT / ST_DONE : FSM state encodings
//   DEFAULT_WIDTH               : default operand width
//   state_t                     : enumerated FSM state type
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/halfadder.sv
// Half-adder primitive.
//   a, b  : input bits
//   sum   : a xor b
//   carry : a and b
module halfadder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder composed of two half adders.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   co   : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  halfadder u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (s1),
    .carry (c1)
  );

  halfadder u_ha1 (
    .a     (s1),
    .b     (cin),
    .sum   (s),
    .carry (c2)
  );

  // Both half-adder carries can never be high together, so OR is exact.
  assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake, a/b sampled on accept
//   out_valid/out_ready : result handshake
//   sum, carry          : a + b mod 2^WIDTH and its carry-out
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last_bit;

  full_adder u_fa (
    .a   (ra_q[0]),
    .b   (rb_q[0]),
    .cin (c_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  // in_ready_q is only ever high while in IDLE, so it alone qualifies accept.
  assign accept   = in_valid && in_ready_q;
  assign last_bit = (cnt_q == LAST_BIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      ra_q       <= '0;
      rb_q       <= '0;
      acc_q      <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      c_q        <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      // Registered so in_ready stays low during reset and never depends
      // combinationally on in_valid or out_ready.
      in_ready_q <= (state_d == IDLE);
      if (accept) begin
        ra_q  <= a;
        rb_q  <= b;
        c_q   <= 1'b0;
        cnt_q <= '0;
      end else if (state_q == SHIFT) begin
        ra_q  <= ra_q >> 1;
        rb_q  <= rb_q >> 1;
        acc_q <= {fa_s, acc_q[WIDTH-1:1]};
        c_q   <= fa_co;
        cnt_q <= cnt_q + CW'(1);
        // Published outputs only change when a full result is ready, so the
        // previous result stays visible while the next one is computed.
        if (last_bit) begin
          sum_q   <= {fa_s, acc_q[WIDTH-1:1]};
          carry_q <= fa_co;
        end
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       carry;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare the currently presented result against the oldest expectation.
  task automatic sb_pop_check(input string tag);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sum"}, 32'(sum), 32'(e[7:0]));
      check({tag, "_carry"}, 32'(carry), 32'(e[8]));
      $display("txn %s: sum=0x%02h carry=%0d expected sum=0x%02h carry=%0d",
               tag, sum, carry, e[7:0], e[8]);
    end
  endtask

  // One complete operation; hold = cycles of back-pressure after out_valid,
  // busy = keep in_valid high with other operands during SHIFT.
  task automatic run_op(input string tag, input logic [7:0] oa, input logic [7:0] ob,
                        input int hold, input bit busy);
    int k;
    logic [8:0] snap;
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    a = oa;
    b = ob;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    exp_q.push_back({1'b0, oa} + {1'b0, ob});
    if (busy) begin
      a = 8'h11;
      b = 8'h22;
    end else begin
      in_valid = 1'b0;
    end
    check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
      if (busy && k == 5) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 32'(k), 32'd8);
    snap = {carry, sum};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_result"}, 32'({carry, sum}), 32'(snap));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    sb_pop_check(tag);
    @(negedge clk);
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pa[20];
    logic [7:0] pb[20];
    int i;
    int got;
    int cyc;
    int last_hs;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;

    // Reset
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_carry", 32'(carry), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_in_ready", 32'(in_ready), 32'd1);

    // Basic sums
    run_op("add_00_00", 8'h00, 8'h00, 0, 1'b0);
    run_op("add_a5_5a", 8'hA5, 8'h5A, 0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 0, 1'b0);

    // Back-pressure
    run_op("bp_7f_01", 8'h7F, 8'h01, 5, 1'b0);

    // Busy-ignore
    run_op("busy_12_34", 8'h12, 8'h34, 0, 1'b1);
    for (int q = 0; q < 12; q++) begin
      @(negedge clk);
      check("busy_no_extra", 32'(out_valid), 32'd0);
    end
    check("busy_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-operation
    check("mid_in_ready", 32'(in_ready), 32'd1);
    a = 8'hC3;
    b = 8'h3C;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("mid_shift_valid", 32'(out_valid), 32'd0);
    end
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_sum", 32'(sum), 32'd0);
      check("mid_rst_carry", 32'(carry), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("mid_release_in_ready", 32'(in_ready), 32'd1);
    check("mid_release_valid", 32'(out_valid), 32'd0);
    run_op("after_rst_80_80", 8'h80, 8'h80, 0, 1'b0);

    // Back-to-back
    for (int p = 0; p < 20; p++) begin
      pa[p] = 8'($urandom_range(0, 255));
      pb[p] = 8'($urandom_range(0, 255));
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    i = 0;
    got = 0;
    cyc = 0;
    last_hs = -10;
    while (got < 20 && cyc < 400) begin
      if (out_valid) begin
        sb_pop_check("b2b");
        got++;
        last_hs = cyc;
      end
      if (in_ready && i < 20) begin
        if (i > 0) check("b2b_gap", 32'(cyc - last_hs), 32'd1);
        a = pa[i];
        b = pb[i];
        exp_q.push_back({1'b0, pa[i]} + {1'b0, pb[i]});
        i++;
      end else if (i >= 20) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("b2b_count", 32'(got), 32'd20);
    check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder with a single carry flip-flop and a full-adder cell built from two `halfadder` instances. It accepts an operand pair on a valid/ready handshake and adds one bit per clock, LSB first. It then presents the WIDTH-bit sum and carry-out on a second valid/ready handshake. It is the sequential stage that consumes the half-adder primitive and trades latency for area against a ripple adder.

## Interface
- WIDTH, 8: operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on a/b is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A, sampled on the input handshake.
- b  input  WIDTH  operand B, sampled on the input handshake.
- out_valid  output  1  sum/carry are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a + b mod 2^WIDTH.
- carry  output  1  carry-out of bit WIDTH-1.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready: load shift registers ra←a and rb←b, clear the carry flop c, clear bit counter cnt (width $clog2(WIDTH)), go to SHIFT.
- **SHIFT**
  - in_ready = 0.
  - Each cycle, full_adder(ra[0], rb[0], c) produces (s, co).
  - Shift sum register right with s entering at the MSB; shift ra and rb right with 0 entering.
  - c←co, cnt←cnt+1.
  - When cnt == WIDTH-1 in this cycle, go to DONE.
- **DONE**
  - out_valid = 1; sum and carry are driven from registers.
  - On out_ready, go to IDLE.
  - While out_ready = 0, sum, carry and out_valid hold stable.
- in_valid asserted outside IDLE is ignored. No operand is queued.
- Arithmetic is unsigned; overflow is reported only via carry.
- Only one operation is in flight at a time. Throughput is one result per WIDTH+2 cycles with out_ready held high.

## Timing
- Reset, while rst is high at a clock edge:
  - state = IDLE, sum = 0, carry = 0, out_valid = 0.
  - in_ready = 0 while rst is high; 1 in the first cycle after rst deasserts.
- Reset mid-operation (in SHIFT or DONE) aborts immediately and discards any partial or unread result. Next cycle is IDLE with outputs at reset values.
- Latency: input handshake at edge E0 → out_valid first high in the cycle after edge E_WIDTH (WIDTH SHIFT edges).
- in_ready and out_valid are decoded from registered state only. No combinational path from in_valid/out_ready to any output.
- Output handshake at edge Ek: out_valid = 0 and in_ready = 1 in the following cycle. A new input may be accepted at edge Ek+1.
- sum and carry keep their last value after the output handshake until the next result overwrites them. Consumers qualify them with out_valid.

## Structure
- serial_adder_pkg holds:
  - state encoding localparams ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2;
  - DEFAULT_WIDTH = 8.
- Sub-module full_adder, consisting of:
  - two `halfadder` instances (a⊕b, then ⊕cin);
  - carry out = carry1 | carry2.
- serial_adder instantiates one full_adder. The rest is the FSM, counter, three shift registers and the carry flop.

## Test plan
All scenarios use WIDTH = 8.
1. Reset:
   - Stimulus: rst high 3 cycles.
   - Response: out_valid = 0, sum = 0x00, carry = 0, in_ready = 0 during reset; in_ready = 1 the first cycle after.
2. Basic sums, out_ready held at 1:
   - 0x00+0x00 → sum 0x00, carry 0.
   - 0xA5+0x5A → sum 0xFF, carry 0.
   - 0xFF+0x01 → sum 0x00, carry 1.
   - For each: out_valid rises exactly 8 cycles after the accept edge.
3. Back-pressure:
   - Stimulus: 0x7F+0x01 with out_ready low for 5 cycles after out_valid rises.
   - Response: sum = 0x80 and carry = 0 stable throughout; out_valid high throughout; in_ready low throughout.
4. Busy-ignore:
   - Stimulus: during SHIFT, drive in_valid = 1 with a = 0x11, b = 0x22.
   - Response: the result still equals the original operation, and no second result appears.
5. Reset mid-operation:
   - Stimulus: start 0xC3+0x3C; assert rst after the 3rd SHIFT cycle.
   - Response: out_valid never rises for that pair; in_ready = 1 the cycle after rst deasserts.
   - Follow-up: 0x80+0x80 → sum 0x00, carry 1.
6. Back-to-back:
   - Stimulus: 20 random pairs with in_valid and out_ready held high.
   - Response: each result matches {carry, sum} = a+b; the input handshake occurs one cycle after each output handshake.
